ft4052c_timegen: RTL and testbench
==================================

# ft4052c_timegen

Frame-readout timing generator for the FT4052C full-frame CCD camera head. On a TRIGGER rising edge it runs one complete exposure: ADC programming, shutter open, integration, shutter close, a 32-byte header slot sequence, then line-by-line CCD readout. Readout drives the CCD clock phases, the AD9826 sampling strobes and the write strobes of the USB FIFO. It sits between the host control registers and the CCD/ADC/FIFO datapath; adc_spi and the header mux are external.

## Interface
- X_TOTAL, 4112: pixel clocks per line.
- Y_TOTAL, 5376: lines per frame.
- X_ACTIVE / Y_ACTIVE, 4008 / 5344: active window size.
- X_OFFSET / Y_OFFSET, 56 / 16: active window start.
- PIX_DIV, 8: CLK cycles per pixel (fixed 8).
- VSTEP, 48: CLK cycles per vertical phase step.
- ADC_LAT, 3: AD9826 pipeline latency in pixels.
- INIT_CYC, 1024: ADC_INIT high duration.
- SHUT_CYC, 480000: shutter pulse width and settle time.
- US_DIV, 48: CLK cycles per integration microsecond.

Ports:
- CLK  in  1  48 MHz clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- INTEGRATION  in  32  exposure time in µs; latched at trigger.
- TRIGGER  in  1  start on rising edge.
- CR, RG, SG  out  1  charge reset, reset gate, summing gate.
- A1..A4  out  1  four-phase image-area clocks.
- C1..C3  out  1  three-phase horizontal-register clocks.
- VA  out  1  current line is inside the Y active window.
- HDR_ENABLE, HDR_R, HDR_ADC_W  out  1  header-phase flag, header read strobe, FIFO write strobe.
- ADC_CLK, ADC_CDS1, ADC_CDS2, ADC_INIT  out  1  AD9826 clock, CDS strobes, start of SPI programming.
- DRV_MAX, DRV_V11, DRV_TG, DRV_LVL  out  1  driver-board controls.
- PARAM_X, PARAM_Y, PARAM_ACTIVE_X, PARAM_ACTIVE_Y, PARAM_OFFSET_X, PARAM_OFFSET_Y  out  16  constant copies of X_TOTAL, Y_TOTAL, X_ACTIVE, Y_ACTIVE, X_OFFSET, Y_OFFSET.
- SHUTTER_ON, SHUTTER_OFF  out  1  shutter open and close coil pulses.

## Operation
- The FSM has states IDLE, INIT, OPEN, INTEG, CLOSE, HEADER, VSHIFT and HREAD.
- IDLE: CR=1, DRV_MAX=1, and every other output is 0. A1/A2 rest at 0 here only.
- A TRIGGER 0→1 transition, detected with a registered previous value, latches INTEGRATION and moves to INIT.
- INIT: ADC_INIT=1 for INIT_CYC cycles.
- OPEN: SHUTTER_ON=1 for SHUT_CYC cycles.
- INTEG: counts INTEGRATION µs using the US_DIV prescaler. INTEGRATION=0 skips this state.
- CLOSE: SHUTTER_OFF=1 for SHUT_CYC cycles, then CR drops.
- DRV_LVL=1 in every state except IDLE. DRV_MAX=1 only in IDLE and INTEG.
- HEADER: HDR_ENABLE=1 for 64 cycles covering 32 bytes. For byte k: HDR_R=1 on cycle 2k, HDR_ADC_W=1 on cycle 2k+1.
- Each line runs VSHIFT then HREAD; the line counter runs 0..Y_TOTAL-1.
- VSHIFT: DRV_TG=1. The line rest state is A1=A2=1, A3=A4=0. Four steps of VSTEP cycles each drive phase pairs in order {A2,A3}, {A3,A4}, {A4,A1}, {A1,A2}, then return to rest.
- HREAD: DRV_V11=1. Runs X_TOTAL pixels, each 8 cycles, with pixel phase p=0..7:
  - RG=1 at p=0.
  - C1=1 for p 0–2, C2=1 for p 3–5, C3=1 for p 6–7.
  - SG=0 for p 4–7, SG=1 otherwise.
  - ADC_CLK=1 for p 0–3.
  - ADC_CDS1=1 at p=2, ADC_CDS2=1 at p=6.
- FIFO writes: HDR_ADC_W=1 at p=1 (high byte) and p=5 (low byte) only when both conditions hold:
  - pixel index is in [X_OFFSET+ADC_LAT, X_OFFSET+ADC_LAT+X_ACTIVE);
  - VA=1.
- VA=1 for line index in [Y_OFFSET, Y_OFFSET+Y_ACTIVE).
- After the last pixel of the last line, return to IDLE.
- TRIGGER edges after the one that started the frame are ignored until IDLE.
- One frame produces exactly 32 + 2·X_ACTIVE·Y_ACTIVE writes.

## Timing
- All outputs are registered. RST asserted forces IDLE output values immediately and clears all counters.
- Reset mid-frame aborts the frame; no further strobes occur until a new trigger.
- The first INIT cycle is the cycle after the clock edge that samples the TRIGGER rise.
- HDR_R and HDR_ADC_W are single-cycle pulses and never coincide.
- Every state transition happens on the cycle after its terminal count.
- Counters are 16-bit for X/Y and 32-bit for the µs count. No wrap occurs within legal parameters.

## Test plan
- Parameters X_TOTAL=8, Y_TOTAL=4, X_ACTIVE=4, Y_ACTIVE=2, offsets 1, ADC_LAT=1, SHUT_CYC=10, INIT_CYC=5, VSTEP=2, INTEGRATION=2. Trigger → exactly 32+16 HDR_ADC_W pulses, then return to IDLE.
- Header phase → 32 HDR_R pulses, each followed by HDR_ADC_W one cycle later; HDR_ENABLE high for exactly 64 cycles.
- INTEGRATION=2 → INTEG lasts 96 cycles; INTEGRATION=0 → CLOSE starts immediately after OPEN.
- Pixel phases in HREAD → check C1/C2/C3, RG, SG, ADC_CLK and CDS1/CDS2 pattern at p=0..7.
- Assert RST during HREAD → CR=1, DRV_MAX=1, all other outputs 0 within the same cycle; a second trigger yields a full frame.
- Hold TRIGGER high, or pulse it during readout → no restart; exactly one frame.

Source files
------------

// File: rtl/ft4052c_timegen.sv
// ft4052c_timegen
// Frame-readout timing generator for the FT4052C full-frame CCD camera head.
// A TRIGGER rising edge starts one exposure:
//   ADC programming -> shutter open -> integration -> shutter close ->
//   32-byte header slot sequence -> line-by-line readout (VSHIFT + HREAD per line).
//
// Ports
//   CLK, RST            clock (rising edge) and asynchronous active-high reset
//   INTEGRATION[31:0]   exposure time in microseconds, latched at trigger
//   TRIGGER             frame start on rising edge
//   CR, RG, SG          charge reset, reset gate, summing gate
//   A1..A4              four-phase image-area clocks
//   C1..C3              three-phase horizontal-register clocks
//   VA                  current line is inside the Y active window
//   HDR_ENABLE, HDR_R   header-phase flag, header byte read strobe
//   HDR_ADC_W           FIFO write strobe (header bytes and pixel bytes)
//   ADC_CLK, ADC_CDS1, ADC_CDS2, ADC_INIT   AD9826 clock, CDS strobes, SPI start
//   DRV_MAX, DRV_V11, DRV_TG, DRV_LVL       driver-board controls
//   PARAM_*[15:0]       constant copies of the frame geometry
//   SHUTTER_ON, SHUTTER_OFF                 shutter coil pulses
module ft4052c_timegen #(
    parameter int X_TOTAL  = 4112,
    parameter int Y_TOTAL  = 5376,
    parameter int X_ACTIVE = 4008,
    parameter int Y_ACTIVE = 5344,
    parameter int X_OFFSET = 56,
    parameter int Y_OFFSET = 16,
    parameter int PIX_DIV  = 8,
    parameter int VSTEP    = 48,
    parameter int ADC_LAT  = 3,
    parameter int INIT_CYC = 1024,
    parameter int SHUT_CYC = 480000,
    parameter int US_DIV   = 48
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INTEGRATION,
    input  logic        TRIGGER,
    output logic        CR,
    output logic        RG,
    output logic        SG,
    output logic        A1,
    output logic        A2,
    output logic        A3,
    output logic        A4,
    output logic        C1,
    output logic        C2,
    output logic        C3,
    output logic        VA,
    output logic        HDR_ENABLE,
    output logic        HDR_R,
    output logic        HDR_ADC_W,
    output logic        ADC_CLK,
    output logic        ADC_CDS1,
    output logic        ADC_CDS2,
    output logic        ADC_INIT,
    output logic        DRV_MAX,
    output logic        DRV_V11,
    output logic        DRV_TG,
    output logic        DRV_LVL,
    output logic [15:0] PARAM_X,
    output logic [15:0] PARAM_Y,
    output logic [15:0] PARAM_ACTIVE_X,
    output logic [15:0] PARAM_ACTIVE_Y,
    output logic [15:0] PARAM_OFFSET_X,
    output logic [15:0] PARAM_OFFSET_Y,
    output logic        SHUTTER_ON,
    output logic        SHUTTER_OFF
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_OPEN, S_INTEG, S_CLOSE, S_HEADER, S_VSHIFT, S_HREAD
    } state_t;

    typedef struct packed {
        logic cr, rg, sg, a1, a2, a3, a4, c1, c2, c3, va;
        logic hdr_enable, hdr_r, hdr_adc_w;
        logic adc_clk, adc_cds1, adc_cds2, adc_init;
        logic drv_max, drv_v11, drv_tg, drv_lvl;
        logic shutter_on, shutter_off;
    } outs_t;

    localparam outs_t      OUTS_IDLE = '{cr: 1'b1, drv_max: 1'b1, default: 1'b0};
    localparam logic [2:0] PH_LAST   = 3'(PIX_DIV - 1);
    localparam logic [15:0] WIN_X_LO = 16'(X_OFFSET + ADC_LAT);
    localparam logic [15:0] WIN_X_HI = 16'(X_OFFSET + ADC_LAT + X_ACTIVE);
    localparam logic [15:0] WIN_Y_LO = 16'(Y_OFFSET);
    localparam logic [15:0] WIN_Y_HI = 16'(Y_OFFSET + Y_ACTIVE);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;      // cycle count within a state / µs prescaler
    logic [31:0] us_q, us_d;        // elapsed integration microseconds
    logic [31:0] integ_q, integ_d;  // INTEGRATION latched at trigger
    logic [1:0]  step_q, step_d;    // vertical phase step
    logic [2:0]  ph_q, ph_d;        // pixel phase
    logic [15:0] pix_q, pix_d;
    logic [15:0] line_q, line_d;
    logic        trig_q, trig_d;
    outs_t       outs_q, outs_d;
    logic        trig_rise;

    assign trig_d    = TRIGGER;
    assign trig_rise = TRIGGER && !trig_q;

    // State and counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            us_q    <= '0;
            integ_q <= '0;
            step_q  <= '0;
            ph_q    <= '0;
            pix_q   <= '0;
            line_q  <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            us_q    <= us_d;
            integ_q <= integ_d;
            step_q  <= step_d;
            ph_q    <= ph_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            trig_q  <= trig_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        us_d    = us_q;
        integ_d = integ_q;
        step_d  = step_q;
        ph_d    = ph_q;
        pix_d   = pix_q;
        line_d  = line_q;
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                us_d   = '0;
                step_d = '0;
                ph_d   = '0;
                pix_d  = '0;
                line_d = '0;
                if (trig_rise) begin
                    state_d = S_INIT;
                    integ_d = INTEGRATION;
                end
            end
            S_INIT: if (cnt_q == 32'(INIT_CYC - 1)) begin
                cnt_d   = '0;
                state_d = S_OPEN;
            end
            S_OPEN: if (cnt_q == 32'(SHUT_CYC - 1)) begin
                cnt_d   = '0;
                us_d    = '0;
                state_d = (integ_q == 32'd0) ? S_CLOSE : S_INTEG;
            end
            S_INTEG: if (cnt_q == 32'(US_DIV - 1)) begin
                cnt_d = '0;
                if (us_q == integ_q - 32'd1) state_d = S_CLOSE;
                else                         us_d    = us_q + 32'd1;
            end
            S_CLOSE: if (cnt_q == 32'(SHUT_CYC - 1)) begin
                cnt_d   = '0;
                state_d = S_HEADER;
            end
            S_HEADER: if (cnt_q == 32'd63) begin
                cnt_d   = '0;
                step_d  = '0;
                line_d  = '0;
                state_d = S_VSHIFT;
            end
            S_VSHIFT: if (cnt_q == 32'(VSTEP - 1)) begin
                cnt_d = '0;
                if (step_q == 2'd3) begin
                    ph_d    = '0;
                    pix_d   = '0;
                    state_d = S_HREAD;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            S_HREAD: begin
                cnt_d = '0;
                ph_d  = ph_q + 3'd1;
                if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (pix_q == 16'(X_TOTAL - 1)) begin
                        pix_d = '0;
                        if (line_q == 16'(Y_TOTAL - 1)) begin
                            state_d = S_IDLE;
                        end else begin
                            line_d  = line_q + 16'd1;
                            step_d  = '0;
                            state_d = S_VSHIFT;
                        end
                    end else begin
                        pix_d = pix_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next-state values so the registered
    // outputs line up with the state they describe.
    always_comb begin
        outs_d = '0;
        if (state_d == S_IDLE) begin
            outs_d = OUTS_IDLE;
        end else begin
            outs_d.drv_lvl = 1'b1;
            outs_d.a1      = 1'b1;
            outs_d.a2      = 1'b1;
            outs_d.va      = (state_d == S_VSHIFT || state_d == S_HREAD) &&
                             (line_d >= WIN_Y_LO) && (line_d < WIN_Y_HI);
        end
        case (state_d)
            S_INIT:  begin outs_d.cr = 1'b1; outs_d.adc_init    = 1'b1; end
            S_OPEN:  begin outs_d.cr = 1'b1; outs_d.shutter_on  = 1'b1; end
            S_INTEG: begin outs_d.cr = 1'b1; outs_d.drv_max     = 1'b1; end
            S_CLOSE: begin outs_d.cr = 1'b1; outs_d.shutter_off = 1'b1; end
            S_HEADER: begin
                // Even cycle reads header byte k, the odd one writes it.
                outs_d.hdr_enable = 1'b1;
                outs_d.hdr_r      = !cnt_d[0];
                outs_d.hdr_adc_w  = cnt_d[0];
            end
            S_VSHIFT: begin
                outs_d.drv_tg = 1'b1;
                case (step_d)
                    2'd0:    {outs_d.a1, outs_d.a2, outs_d.a3, outs_d.a4} = 4'b0110;
                    2'd1:    {outs_d.a1, outs_d.a2, outs_d.a3, outs_d.a4} = 4'b0011;
                    2'd2:    {outs_d.a1, outs_d.a2, outs_d.a3, outs_d.a4} = 4'b1001;
                    default: {outs_d.a1, outs_d.a2, outs_d.a3, outs_d.a4} = 4'b1100;
                endcase
            end
            S_HREAD: begin
                outs_d.drv_v11  = 1'b1;
                outs_d.rg       = (ph_d == 3'd0);
                outs_d.c1       = (ph_d <= 3'd2);
                outs_d.c2       = (ph_d >= 3'd3) && (ph_d <= 3'd5);
                outs_d.c3       = (ph_d >= 3'd6);
                outs_d.sg       = (ph_d <= 3'd3);
                outs_d.adc_clk  = (ph_d <= 3'd3);
                outs_d.adc_cds1 = (ph_d == 3'd2);
                outs_d.adc_cds2 = (ph_d == 3'd6);
                // ADC output lags the sampled pixel by ADC_LAT pixels,
                // so the write window is shifted by that latency.
                outs_d.hdr_adc_w = outs_d.va && (ph_d == 3'd1 || ph_d == 3'd5) &&
                                   (pix_d >= WIN_X_LO) && (pix_d < WIN_X_HI);
            end
            default: ;
        endcase
    end

    // Output register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) outs_q <= OUTS_IDLE;
        else     outs_q <= outs_d;
    end

    assign CR          = outs_q.cr;
    assign RG          = outs_q.rg;
    assign SG          = outs_q.sg;
    assign A1          = outs_q.a1;
    assign A2          = outs_q.a2;
    assign A3          = outs_q.a3;
    assign A4          = outs_q.a4;
    assign C1          = outs_q.c1;
    assign C2          = outs_q.c2;
    assign C3          = outs_q.c3;
    assign VA          = outs_q.va;
    assign HDR_ENABLE  = outs_q.hdr_enable;
    assign HDR_R       = outs_q.hdr_r;
    assign HDR_ADC_W   = outs_q.hdr_adc_w;
    assign ADC_CLK     = outs_q.adc_clk;
    assign ADC_CDS1    = outs_q.adc_cds1;
    assign ADC_CDS2    = outs_q.adc_cds2;
    assign ADC_INIT    = outs_q.adc_init;
    assign DRV_MAX     = outs_q.drv_max;
    assign DRV_V11     = outs_q.drv_v11;
    assign DRV_TG      = outs_q.drv_tg;
    assign DRV_LVL     = outs_q.drv_lvl;
    assign SHUTTER_ON  = outs_q.shutter_on;
    assign SHUTTER_OFF = outs_q.shutter_off;

    assign PARAM_X        = 16'(X_TOTAL);
    assign PARAM_Y        = 16'(Y_TOTAL);
    assign PARAM_ACTIVE_X = 16'(X_ACTIVE);
    assign PARAM_ACTIVE_Y = 16'(Y_ACTIVE);
    assign PARAM_OFFSET_X = 16'(X_OFFSET);
    assign PARAM_OFFSET_Y = 16'(Y_OFFSET);

endmodule

// File: tb/tb_ft4052c_timegen.sv
// Bench for ft4052c_timegen with a reduced frame geometry. A cycle-level
// reference computes the expected outputs from the frame's segment lengths.
module tb_ft4052c_timegen;

    localparam int XT = 8, YT = 4, XA = 4, YA = 2, XO = 1, YO = 1;
    localparam int LAT = 1, VST = 2, INITC = 5, SHUT = 10, USD = 48;
    localparam int LINE = 4 * VST + XT * 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] INTEGRATION;
    logic        TRIGGER;
    logic CR, RG, SG, A1, A2, A3, A4, C1, C2, C3, VA;
    logic HDR_ENABLE, HDR_R, HDR_ADC_W, ADC_CLK, ADC_CDS1, ADC_CDS2, ADC_INIT;
    logic DRV_MAX, DRV_V11, DRV_TG, DRV_LVL, SHUTTER_ON, SHUTTER_OFF;
    logic [15:0] PARAM_X, PARAM_Y, PARAM_ACTIVE_X, PARAM_ACTIVE_Y, PARAM_OFFSET_X, PARAM_OFFSET_Y;

    int tests = 0;
    int fails = 0;

    ft4052c_timegen #(
        .X_TOTAL(XT), .Y_TOTAL(YT), .X_ACTIVE(XA), .Y_ACTIVE(YA),
        .X_OFFSET(XO), .Y_OFFSET(YO), .PIX_DIV(8), .VSTEP(VST), .ADC_LAT(LAT),
        .INIT_CYC(INITC), .SHUT_CYC(SHUT), .US_DIV(USD)
    ) dut (
        .CLK(CLK), .RST(RST), .INTEGRATION(INTEGRATION), .TRIGGER(TRIGGER),
        .CR(CR), .RG(RG), .SG(SG), .A1(A1), .A2(A2), .A3(A3), .A4(A4),
        .C1(C1), .C2(C2), .C3(C3), .VA(VA),
        .HDR_ENABLE(HDR_ENABLE), .HDR_R(HDR_R), .HDR_ADC_W(HDR_ADC_W),
        .ADC_CLK(ADC_CLK), .ADC_CDS1(ADC_CDS1), .ADC_CDS2(ADC_CDS2), .ADC_INIT(ADC_INIT),
        .DRV_MAX(DRV_MAX), .DRV_V11(DRV_V11), .DRV_TG(DRV_TG), .DRV_LVL(DRV_LVL),
        .PARAM_X(PARAM_X), .PARAM_Y(PARAM_Y),
        .PARAM_ACTIVE_X(PARAM_ACTIVE_X), .PARAM_ACTIVE_Y(PARAM_ACTIVE_Y),
        .PARAM_OFFSET_X(PARAM_OFFSET_X), .PARAM_OFFSET_Y(PARAM_OFFSET_Y),
        .SHUTTER_ON(SHUTTER_ON), .SHUTTER_OFF(SHUTTER_OFF)
    );

    always #5 CLK = ~CLK;

    logic [23:0] obs_vec;
    assign obs_vec = {CR, RG, SG, A1, A2, A3, A4, C1, C2, C3, VA,
                      HDR_ENABLE, HDR_R, HDR_ADC_W, ADC_CLK, ADC_CDS1, ADC_CDS2, ADC_INIT,
                      DRV_MAX, DRV_V11, DRV_TG, DRV_LVL, SHUTTER_ON, SHUTTER_OFF};

    function automatic int frame_len(input int integ);
        return INITC + 2 * SHUT + integ * USD + 64 + YT * LINE;
    endfunction

    function automatic int readout_start(input int integ);
        return INITC + 2 * SHUT + integ * USD + 64;
    endfunction

    // Expected outputs t cycles after the first INIT cycle (t<0 or past the
    // end of the frame means idle).
    function automatic logic [23:0] model(input int t, input int integ);
        logic cr, rg, sg, a1, a2, a3, a4, c1, c2, c3, va, he, hr, hw;
        logic ac, cd1, cd2, ai, dmax, dv11, dtg, dlvl, son, soff;
        int b0, b1, b2, b3, b4, r, ln, w, q, px, p;
        {cr, rg, sg, a1, a2, a3, a4, c1, c2, c3, va, he, hr, hw} = '0;
        {ac, cd1, cd2, ai, dmax, dv11, dtg, dlvl, son, soff} = '0;
        b0 = INITC; b1 = b0 + SHUT; b2 = b1 + integ * USD; b3 = b2 + SHUT; b4 = b3 + 64;
        if (t < 0 || t >= frame_len(integ)) begin
            cr = 1; dmax = 1;
        end else begin
            dlvl = 1; a1 = 1; a2 = 1;
            if (t < b0)      begin cr = 1; ai = 1; end
            else if (t < b1) begin cr = 1; son = 1; end
            else if (t < b2) begin cr = 1; dmax = 1; end
            else if (t < b3) begin cr = 1; soff = 1; end
            else if (t < b4) begin
                he = 1; hr = ((t - b3) % 2 == 0); hw = ((t - b3) % 2 == 1);
            end else begin
                r = t - b4; ln = r / LINE; w = r % LINE;
                va = (ln >= YO) && (ln < YO + YA);
                if (w < 4 * VST) begin
                    dtg = 1;
                    case (w / VST)
                        0: {a1, a2, a3, a4} = 4'b0110;
                        1: {a1, a2, a3, a4} = 4'b0011;
                        2: {a1, a2, a3, a4} = 4'b1001;
                        default: {a1, a2, a3, a4} = 4'b1100;
                    endcase
                end else begin
                    dv11 = 1; q = w - 4 * VST; px = q / 8; p = q % 8;
                    rg = (p == 0); c1 = (p < 3); c2 = (p >= 3 && p < 6); c3 = (p >= 6);
                    sg = (p < 4); ac = (p < 4); cd1 = (p == 2); cd2 = (p == 6);
                    hw = va && (p == 1 || p == 5) && (px >= XO + LAT) && (px < XO + LAT + XA);
                end
            end
        end
        return {cr, rg, sg, a1, a2, a3, a4, c1, c2, c3, va, he, hr, hw,
                ac, cd1, cd2, ai, dmax, dv11, dtg, dlvl, son, soff};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Runs a frame with TRIGGER held high (or randomly toggled during the
    // frame when glitch=1) and checks every cycle, then that no restart occurs.
    task automatic run_frame(input int integ, input bit glitch);
        int len, nw, nr, ne, nm;
        len = frame_len(integ);
        nw = 0; nr = 0; ne = 0; nm = 0;
        INTEGRATION = 32'(integ);
        TRIGGER = 1'b1;
        tick();
        INTEGRATION = $urandom;
        for (int t = 0; t < len; t++) begin
            check("frame", t, 32'(obs_vec), 32'(model(t, integ)));
            nw += int'(HDR_ADC_W); nr += int'(HDR_R); ne += int'(HDR_ENABLE); nm += int'(DRV_MAX);
            if (HDR_R && HDR_ADC_W) check("r_w_overlap", t, 32'd1, 32'd0);
            if (glitch && t < len - 5) TRIGGER = 1'($urandom_range(0, 1));
            else                       TRIGGER = 1'b1;
            tick();
        end
        check("writes", len, 32'(nw), 32'(32 + 2 * XA * YA));
        check("hdr_reads", len, 32'(nr), 32'd32);
        check("hdr_enable_len", len, 32'(ne), 32'd64);
        check("integ_len", len, 32'(nm), 32'(integ * USD));
        for (int t = len; t < len + 20; t++) begin
            check("no_restart", t, 32'(obs_vec), 32'(model(t, integ)));
            tick();
        end
        TRIGGER = 1'b0;
        tick();
    endtask

    initial begin
        int integ, tr;
        RST = 1'b1;
        TRIGGER = 1'b0;
        INTEGRATION = '0;
        tick();
        check("reset_idle", 0, 32'(obs_vec), 32'(model(-1, 0)));
        check("param_x", 0, 32'(PARAM_X), 32'(XT));
        check("param_y", 0, 32'(PARAM_Y), 32'(YT));
        check("param_ax", 0, 32'(PARAM_ACTIVE_X), 32'(XA));
        check("param_ay", 0, 32'(PARAM_ACTIVE_Y), 32'(YA));
        check("param_ox", 0, 32'(PARAM_OFFSET_X), 32'(XO));
        check("param_oy", 0, 32'(PARAM_OFFSET_Y), 32'(YO));
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("idle", i, 32'(obs_vec), 32'(model(-1, 0)));
            tick();
        end

        run_frame(2, 1'b0);
        run_frame(0, 1'b0);
        run_frame(int'($urandom_range(1, 3)), 1'b1);

        // Abort a frame during readout of line 1.
        integ = int'($urandom_range(0, 2));
        tr = readout_start(integ) + LINE + 4 * VST + int'($urandom_range(0, 8 * XT - 1));
        INTEGRATION = 32'(integ);
        TRIGGER = 1'b1;
        tick();
        for (int t = 0; t < tr; t++) begin
            check("pre_abort", t, 32'(obs_vec), 32'(model(t, integ)));
            tick();
        end
        RST = 1'b1;
        TRIGGER = 1'b0;
        #1;
        check("abort_immediate", tr, 32'(obs_vec), 32'(model(-1, 0)));
        tick();
        check("abort_held", tr, 32'(obs_vec), 32'(model(-1, 0)));
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_abort_idle", i, 32'(obs_vec), 32'(model(-1, 0)));
        end
        run_frame(2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
